// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and op-decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_mul_hi(input logic [2:0] op);
    return !op[2] && (op[1:0] != 2'b00);
  endfunction

  // MUL is treated as unsigned: its low word is identical for any signedness.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Operand magnitude extraction (IDLE) and conditional result negation (FIX).
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   i_src_a,
  input  logic [XLEN-1:0]   i_src_b,
  input  logic              i_signed_a,
  input  logic              i_signed_b,
  output logic              o_neg_a,
  output logic              o_neg_b,
  output logic [XLEN-1:0]   o_mag_a,
  output logic [XLEN-1:0]   o_mag_b,
  input  logic [2*XLEN-1:0] i_fix_val,
  input  logic              i_fix_neg,
  output logic [2*XLEN-1:0] o_fix_val
);

  assign o_neg_a   = i_signed_a & i_src_a[XLEN-1];
  assign o_neg_b   = i_signed_b & i_src_b[XLEN-1];
  assign o_mag_a   = o_neg_a ? -i_src_a : i_src_a;
  assign o_mag_b   = o_neg_b ? -i_src_b : i_src_b;
  assign o_fix_val = i_fix_neg ? -i_fix_val : i_fix_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add / restoring divide on magnitudes,
// then a sign-fix cycle. Handshake: start is accepted only in IDLE; done pulses with result.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      o_dbg_state
);

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic [4:0]          r_cnt;
  logic                r_neg_ab;
  logic                r_neg_a;
  logic [XLEN-1:0]     r_result;

  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_step;
  logic [2*XLEN:0]     w_div_shift;
  logic                w_div_ge;
  logic [XLEN:0]       w_div_diff;
  logic [2*XLEN-1:0]   w_div_step;
  logic [2*XLEN-1:0]   w_fix_in;
  logic                w_fix_neg;
  logic [2*XLEN-1:0]   w_fix_out;
  logic [XLEN-1:0]     w_fix_result;

  muldiv_signfix u_signfix (
    .i_src_a    (SrcA),
    .i_src_b    (SrcB),
    .i_signed_a (is_signed_a(op)),
    .i_signed_b (is_signed_b(op)),
    .o_neg_a    (w_neg_a),
    .o_neg_b    (w_neg_b),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .i_fix_val  (w_fix_in),
    .i_fix_neg  (w_fix_neg),
    .o_fix_val  (w_fix_out)
  );

  assign w_div_zero = is_div(op) && (SrcB == '0);
  assign w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                      (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero | w_div_ovf;

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_ge    = w_div_shift[2*XLEN:XLEN] >= {1'b0, r_b};
  assign w_div_diff  = w_div_shift[2*XLEN:XLEN] - {1'b0, r_b};
  assign w_div_step  = w_div_ge ? {w_div_diff[XLEN-1:0], w_div_shift[XLEN-1:1], 1'b1}
                                : w_div_shift[2*XLEN-1:0];

  assign w_fix_in = !is_div(r_op) ? r_acc :
                    is_rem(r_op)  ? {{XLEN{1'b0}}, r_acc[2*XLEN-1:XLEN]} :
                                    {{XLEN{1'b0}}, r_acc[XLEN-1:0]};
  assign w_fix_neg    = is_rem(r_op) ? r_neg_a : r_neg_ab;
  assign w_fix_result = is_mul_hi(r_op) ? w_fix_out[2*XLEN-1:XLEN] : w_fix_out[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Special cases skip CALC: the answer is preloaded and passes through FIX unchanged.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = w_special ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == 5'd31) w_next_state = S_FIX;
      S_FIX:  w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    result      = r_result;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg_ab <= 1'b0;
      r_neg_a  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_cnt <= '0;
            r_b   <= w_mag_b;
            if (w_div_zero) begin
              r_acc    <= {SrcA, {XLEN{1'b1}}};
              r_neg_ab <= 1'b0;
              r_neg_a  <= 1'b0;
            end else if (w_div_ovf) begin
              r_acc    <= {{XLEN{1'b0}}, 32'h8000_0000};
              r_neg_ab <= 1'b0;
              r_neg_a  <= 1'b0;
            end else begin
              r_acc    <= {{XLEN{1'b0}}, w_mag_a};
              r_neg_ab <= w_neg_a ^ w_neg_b;
              r_neg_a  <= w_neg_a;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          r_acc <= is_div(r_op) ? w_div_step : w_mul_step;
        end
        S_FIX:   r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

endmodule
